// File: rtl/riscv_dport_pkg.sv
// Shared types for the riscv_core data-port responder: response queue entry,
// request error classes and the default tag width.
package riscv_dport_pkg;

  localparam int DPORT_TAG_W = 11;

  // Tag is held at full 32-bit width so one entry type serves any TAG_W.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] data;
    logic        error;
    logic [3:0]  countdown;
  } resp_entry_t;

  typedef enum logic [1:0] {
    CLS_OK    = 2'd0,
    CLS_MULTI = 2'd1,
    CLS_RANGE = 2'd2
  } err_class_e;

  // Number of distinct request kinds (read, write, maintenance) asserted at once.
  function automatic logic [1:0] req_kinds(input logic rd, input logic wr_any, input logic maint);
    return {1'b0, rd} + {1'b0, wr_any} + {1'b0, maint};
  endfunction

endpackage

// File: rtl/dport_resp_fifo.sv
// Circular response FIFO; every entry counts down to zero and the head is
// reported ready once its countdown has expired.
module dport_resp_fifo
  import riscv_dport_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  resp_entry_t push_entry,
  input  logic        pop,
  output resp_entry_t head,
  output logic        head_ready,
  output logic [4:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t   entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Payload storage needs no reset; validity is carried by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].countdown != 4'd0) begin
        entries[i].countdown <= entries[i].countdown - 4'd1;
      end
    end
    if (push) begin
      entries[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop) begin
        count <= count + 5'd1;
      end else if (pop && !push) begin
        count <= count - 5'd1;
      end
    end
  end

  assign head       = entries[rd_ptr];
  assign head_ready = (count != 5'd0) && (head.countdown == 4'd0);

endmodule

// File: rtl/riscv_dport_mem_responder.sv
// Data-port slave model for riscv_core: word memory with byte strobes,
// fixed-latency in-order tagged responses, back-pressure and error responses.
module riscv_dport_mem_responder
  import riscv_dport_pkg::*;
#(
  parameter logic [31:0] MEM_BASE        = 32'h8000_0000,
  parameter int          MEM_AW          = 10,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          TAG_W           = DPORT_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic             mem_d_cacheable_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  input  logic             stall_i,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o,
  output logic [31:0]      mem_d_data_rd_o,
  output logic [4:0]       outstanding_o,
  output logic [15:0]      err_cnt_o
);

  localparam int WORDS = 1 << MEM_AW;

  logic [31:0]       mem [WORDS];
  logic              wr_any;
  logic              maint;
  logic              req;
  logic              fire;
  logic              in_window;
  logic [31:0]       offset;
  logic [MEM_AW-1:0] idx;
  err_class_e        err_class;
  resp_entry_t       push_entry;
  resp_entry_t       head;
  logic              head_ready;
  logic [4:0]        count;
  logic              unused_bits;

  assign wr_any    = |mem_d_wr_i;
  assign maint     = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
  assign req       = mem_d_rd_i | wr_any | maint;
  // Unsigned wrap-around makes addresses below MEM_BASE land far out of range.
  assign offset    = mem_d_addr_i - MEM_BASE;
  assign in_window = (offset >> (MEM_AW + 2)) == 32'd0;
  assign idx       = offset[MEM_AW+1:2];

  assign mem_d_accept_o = !rst_i && !stall_i && (count < 5'(MAX_OUTSTANDING));
  assign fire           = req && mem_d_accept_o;
  assign outstanding_o  = count;

  always_comb begin
    err_class = CLS_OK;
    if (req_kinds(mem_d_rd_i, wr_any, maint) > 2'd1) begin
      err_class = CLS_MULTI;
    end else if ((mem_d_rd_i || wr_any) && !in_window) begin
      err_class = CLS_RANGE;
    end
  end

  always_comb begin
    push_entry           = '0;
    push_entry.tag       = 32'(mem_d_req_tag_i);
    push_entry.error     = (err_class != CLS_OK);
    push_entry.countdown = 4'(LATENCY - 1);
    if (err_class == CLS_OK && mem_d_rd_i) begin
      push_entry.data = mem[idx];
    end
  end

  // Memory is deliberately outside the reset domain so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (fire && wr_any && err_class == CLS_OK) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_d_wr_i[b]) mem[idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
      end
    end
  end

  dport_resp_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (fire),
    .push_entry(push_entry),
    .pop       (head_ready),
    .head      (head),
    .head_ready(head_ready),
    .count     (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_d_ack_o      <= 1'b0;
      mem_d_error_o    <= 1'b0;
      mem_d_resp_tag_o <= '0;
      mem_d_data_rd_o  <= 32'd0;
      err_cnt_o        <= 16'd0;
    end else begin
      mem_d_ack_o <= head_ready;
      if (head_ready) begin
        mem_d_error_o    <= head.error;
        mem_d_resp_tag_o <= head.tag[TAG_W-1:0];
        mem_d_data_rd_o  <= head.data;
        if (head.error && err_cnt_o != 16'hFFFF) begin
          err_cnt_o <= err_cnt_o + 16'd1;
        end
      end
    end
  end

  assign unused_bits = ^{mem_d_cacheable_i, head.tag, offset[1:0]};

endmodule

// File: tb/tb_riscv_dport_mem_responder.sv
// Directed bench for riscv_dport_mem_responder: vector table for single
// transactions plus hand sequences for stall, queue-full and reset.
module tb_riscv_dport_mem_responder;

  localparam int LAT      = 2;
  localparam int DEEP_LAT = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default-parameter instance
  logic [31:0] addr = '0, wdata = '0;
  logic        rd = 1'b0, cacheable = 1'b0, inval = 1'b0, wb = 1'b0, flush = 1'b0, stall = 1'b0;
  logic [3:0]  wr = '0;
  logic [10:0] req_tag = '0;
  logic        accept, ack, error;
  logic [10:0] resp_tag;
  logic [31:0] data_rd;
  logic [4:0]  outstanding;
  logic [15:0] err_cnt;

  // long-latency instance used to fill the response queue
  logic        d_rd = 1'b0;
  logic [31:0] d_addr = 32'h8000_0020;
  logic [10:0] d_tag = '0;
  logic        d_accept, d_ack, d_error;
  logic [10:0] d_resp_tag;
  logic [31:0] d_data;
  logic [4:0]  d_outstanding;
  logic [15:0] d_err_cnt;

  riscv_dport_mem_responder u_dut (
    .clk_i(clk), .rst_i(rst),
    .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata), .mem_d_rd_i(rd), .mem_d_wr_i(wr),
    .mem_d_cacheable_i(cacheable), .mem_d_req_tag_i(req_tag),
    .mem_d_invalidate_i(inval), .mem_d_writeback_i(wb), .mem_d_flush_i(flush),
    .stall_i(stall), .mem_d_accept_o(accept), .mem_d_ack_o(ack), .mem_d_error_o(error),
    .mem_d_resp_tag_o(resp_tag), .mem_d_data_rd_o(data_rd),
    .outstanding_o(outstanding), .err_cnt_o(err_cnt)
  );

  riscv_dport_mem_responder #(.LATENCY(DEEP_LAT)) u_deep (
    .clk_i(clk), .rst_i(rst),
    .mem_d_addr_i(d_addr), .mem_d_data_wr_i(32'd0), .mem_d_rd_i(d_rd), .mem_d_wr_i(4'd0),
    .mem_d_cacheable_i(1'b0), .mem_d_req_tag_i(d_tag),
    .mem_d_invalidate_i(1'b0), .mem_d_writeback_i(1'b0), .mem_d_flush_i(1'b0),
    .stall_i(1'b0), .mem_d_accept_o(d_accept), .mem_d_ack_o(d_ack), .mem_d_error_o(d_error),
    .mem_d_resp_tag_o(d_resp_tag), .mem_d_data_rd_o(d_data),
    .outstanding_o(d_outstanding), .err_cnt_o(d_err_cnt)
  );

  typedef struct packed {
    logic        rd;
    logic [3:0]  wr;
    logic [2:0]  maint;     // {invalidate, writeback, flush}
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [10:0] tag;
    logic        exp_err;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [15:0] exp_errcnt;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  // scoreboard
  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] w, input logic [2:0] m,
                              input logic [31:0] a, input logic [31:0] d, input logic [10:0] t,
                              input logic e, input logic c, input logic [31:0] x,
                              input logic [15:0] ec);
    vec_t v;
    v.rd = r; v.wr = w; v.maint = m; v.addr = a; v.wdata = d; v.tag = t;
    v.exp_err = e; v.chk_data = c; v.exp_data = x; v.exp_errcnt = ec;
    return v;
  endfunction

  // drivers
  task automatic drive_req(input vec_t v);
    rd = v.rd; wr = v.wr; {inval, wb, flush} = v.maint;
    addr = v.addr; wdata = v.wdata; req_tag = v.tag;
  endtask

  task automatic idle_main();
    rd = 1'b0; wr = 4'd0; inval = 1'b0; wb = 1'b0; flush = 1'b0;
  endtask

  // Single transaction: must be accepted immediately and acked LAT edges later.
  task automatic run_vec(input string id, input vec_t v);
    int n;
    drive_req(v);
    #1;
    check({id, " accept"}, 32'(accept), 32'd1);
    @(posedge clk); #1;
    idle_main();
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack) break;
    end
    check({id, " latency"}, n, LAT);
    check({id, " tag"}, 32'(resp_tag), 32'(v.tag));
    check({id, " error"}, 32'(error), 32'(v.exp_err));
    if (v.chk_data) check({id, " data"}, data_rd, v.exp_data);
    check({id, " err_cnt"}, 32'(err_cnt), 32'(v.exp_errcnt));
  endtask

  logic [10:0] exp_tag_q[$];
  int          exp_cyc_q[$];

  initial begin
    int issued, acked, blocked, peak, first_ack_cyc, fifth_fire_cyc, late_acks;
    logic [10:0] t;
    int cy;

    //              rd  wr      maint   addr           wdata          tag     err chk exp_data       errcnt
    vecs[0]  = mk(1'b0, 4'hF, 3'b000, 32'h8000_0004, 32'hA5A5_A5A5, 11'h011, 1'b0, 1'b0, 32'h0,         16'd0);
    vecs[1]  = mk(1'b1, 4'h0, 3'b000, 32'h8000_0004, 32'h0,         11'h012, 1'b0, 1'b1, 32'hA5A5_A5A5, 16'd0);
    vecs[2]  = mk(1'b0, 4'h2, 3'b000, 32'h8000_0004, 32'h0000_3C00, 11'h013, 1'b0, 1'b0, 32'h0,         16'd0);
    vecs[3]  = mk(1'b1, 4'h0, 3'b000, 32'h8000_0004, 32'h0,         11'h014, 1'b0, 1'b1, 32'hA5A5_3CA5, 16'd0);
    vecs[4]  = mk(1'b0, 4'hF, 3'b000, 32'h7FFF_FFFC, 32'h5A5A_5A5A, 11'h015, 1'b1, 1'b1, 32'h0,         16'd1);
    vecs[5]  = mk(1'b1, 4'h0, 3'b000, 32'h8000_0004, 32'h0,         11'h016, 1'b0, 1'b1, 32'hA5A5_3CA5, 16'd1);
    vecs[6]  = mk(1'b1, 4'h1, 3'b000, 32'h8000_0004, 32'hFFFF_FFFF, 11'h017, 1'b1, 1'b1, 32'h0,         16'd2);
    vecs[7]  = mk(1'b1, 4'h0, 3'b000, 32'h8000_0004, 32'h0,         11'h018, 1'b0, 1'b1, 32'hA5A5_3CA5, 16'd2);
    vecs[8]  = mk(1'b0, 4'h0, 3'b001, 32'h8000_0004, 32'h0,         11'h019, 1'b0, 1'b0, 32'h0,         16'd2);
    vecs[9]  = mk(1'b1, 4'h0, 3'b000, 32'h8000_1000, 32'h0,         11'h01A, 1'b1, 1'b1, 32'h0,         16'd3);
    vecs[10] = mk(1'b0, 4'hF, 3'b000, 32'h8000_0FFC, 32'h1234_5678, 11'h01B, 1'b0, 1'b0, 32'h0,         16'd3);
    vecs[11] = mk(1'b1, 4'h0, 3'b000, 32'h8000_0FFC, 32'h0,         11'h01C, 1'b0, 1'b1, 32'h1234_5678, 16'd3);
    vecs[12] = mk(1'b0, 4'hF, 3'b000, 32'h8000_0000, 32'hCAFE_F00D, 11'h01D, 1'b0, 1'b0, 32'h0,         16'd3);
    vecs[13] = mk(1'b1, 4'h0, 3'b000, 32'h8000_0000, 32'h0,         11'h7FF, 1'b0, 1'b1, 32'hCAFE_F00D, 16'd3);
    vecs[14] = mk(1'b0, 4'h0, 3'b110, 32'h8000_0004, 32'h0,         11'h01E, 1'b0, 1'b0, 32'h0,         16'd3);
    vecs[15] = mk(1'b1, 4'h0, 3'b010, 32'h8000_0004, 32'h0,         11'h01F, 1'b1, 1'b1, 32'h0,         16'd4);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst accept", 32'(accept), 32'd0);
    check("rst ack", 32'(ack), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst tag", 32'(resp_tag), 32'd0);
    check("rst data", data_rd, 32'd0);
    check("rst outstanding", 32'(outstanding), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    cacheable = 1'b1;
    #1;
    check("post-rst accept", 32'(accept), 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // a queued response is not delayed by stall; a held request waits it out
    drive_req(mk(1'b1, 4'h0, 3'b000, 32'h8000_0004, 32'h0, 11'h021, 1'b0, 1'b1, 32'h0, 16'd4));
    #1;
    check("stall pre accept", 32'(accept), 32'd1);
    @(posedge clk); #1;
    stall = 1'b1;
    req_tag = 11'h022;
    #1;
    check("stall c1 accept", 32'(accept), 32'd0);
    check("stall outstanding", 32'(outstanding), 32'd1);
    @(posedge clk); #1;
    check("stall c2 accept", 32'(accept), 32'd0);
    check("stall c2 no ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    check("stall c3 accept", 32'(accept), 32'd0);
    check("stall queued ack", 32'(ack), 32'd1);
    check("stall queued tag", 32'(resp_tag), 32'h021);
    stall = 1'b0;
    run_vec("after-stall", mk(1'b1, 4'h0, 3'b000, 32'h8000_0004, 32'h0, 11'h022,
                             1'b0, 1'b1, 32'hA5A5_3CA5, 16'd4));

    // five back-to-back reads into a 4-deep queue with latency 6
    issued = 0; acked = 0; blocked = 0; peak = 0; first_ack_cyc = -1; fifth_fire_cyc = -1;
    for (int c = 0; c < 60 && acked < 5; c++) begin
      d_rd  = (issued < 5);
      d_tag = 11'h100 + 11'(issued);
      #1;
      if (d_rd && d_accept) begin
        exp_tag_q.push_back(d_tag);
        exp_cyc_q.push_back(c + DEEP_LAT);
        if (issued == 4) fifth_fire_cyc = c;
        issued++;
      end else if (d_rd) begin
        blocked++;
      end
      @(posedge clk); #1;
      if (32'(d_outstanding) > peak) peak = 32'(d_outstanding);
      if (d_ack) begin
        if (acked == 0) first_ack_cyc = c;
        if (exp_tag_q.size() == 0) begin
          check("deep spurious ack", 32'd1, 32'd0);
        end else begin
          t  = exp_tag_q.pop_front();
          cy = exp_cyc_q.pop_front();
          check($sformatf("deep ack%0d tag", acked), 32'(d_resp_tag), 32'(t));
          check($sformatf("deep ack%0d cycle", acked), c, cy);
          check($sformatf("deep ack%0d error", acked), 32'(d_error), 32'd0);
        end
        acked++;
      end
    end
    d_rd = 1'b0;
    check("deep acks", acked, 5);
    check("deep peak outstanding", peak, 4);
    check("deep blocked cycles", blocked, 3);
    check("deep 5th fire after first ack", fifth_fire_cyc, first_ack_cyc + 1);

    // reset with three responses pending
    for (int c = 0; c < 3; c++) begin
      d_rd  = 1'b1;
      d_tag = 11'h200 + 11'(c);
      @(posedge clk); #1;
    end
    d_rd = 1'b0;
    check("pre-rst outstanding", 32'(d_outstanding), 32'd3);
    rst = 1'b1;
    #1;
    check("mid-rst deep accept", 32'(d_accept), 32'd0);
    check("mid-rst deep outstanding", 32'(d_outstanding), 32'd0);
    check("mid-rst deep data", d_data, 32'd0);
    check("mid-rst accept", 32'(accept), 32'd0);
    check("mid-rst err_cnt", 32'(err_cnt), 32'd0);
    late_acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (d_ack) late_acks++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (d_ack) late_acks++;
    end
    check("discarded acks", late_acks, 0);
    check("post-rst deep outstanding", 32'(d_outstanding), 32'd0);
    check("deep err_cnt", 32'(d_err_cnt), 32'd0);
    run_vec("retained", mk(1'b1, 4'h0, 3'b000, 32'h8000_0004, 32'h0, 11'h030,
                          1'b0, 1'b1, 32'hA5A5_3CA5, 16'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
